// File: rtl/data_io_bridge.sv
// CPU data-port bridge: RAM/IO decode, LED, cycle counter, UART TX with FIFO.
// Read data 1 cycle after address for both RAM and IO; ram_we is combinational.
// No stall to the CPU: TX pushes into a full FIFO are dropped and flag overflow.
module data_io_bridge #(
  parameter logic [13:0] IO_BASE    = 14'h3FF0,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BAUD_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [13:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  output logic [31:0] cpu_rdata,
  output logic        ram_we,
  input  logic [31:0] ram_rdata,
  output logic [7:0]  led,
  output logic        uart_tx,
  output logic        irq_tx_empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          w_io_sel;
  logic [3:0]    w_idx;
  logic          w_wr_io;
  logic          w_wr_led, w_wr_cyc, w_wr_stat, w_wr_tx, w_wr_baud;
  logic [31:0]   w_io_val;
  logic [31:0]   w_status;

  logic [7:0]    r_led;
  logic [31:0]   r_cycle;
  logic [15:0]   r_baud;
  logic          r_ovf;
  logic          r_sel_q;
  logic [31:0]   r_io_rdata_q;
  logic          r_irq;

  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic          w_full, w_empty, w_push, w_pop;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [15:0]   r_bcnt, w_bcnt_nxt;
  logic [2:0]    r_bidx, w_bidx_nxt;
  logic [15:0]   w_reload;
  logic          w_tx;

  assign w_io_sel  = (cpu_addr[13:4] == IO_BASE[13:4]);
  assign w_idx     = cpu_addr[3:0];
  assign w_wr_io   = cpu_we & w_io_sel;
  assign w_wr_led  = w_wr_io & (w_idx == 4'd0);
  assign w_wr_cyc  = w_wr_io & (w_idx == 4'd1);
  assign w_wr_stat = w_wr_io & (w_idx == 4'd2);
  assign w_wr_tx   = w_wr_io & (w_idx == 4'd3);
  assign w_wr_baud = w_wr_io & (w_idx == 4'd4);

  assign ram_we    = cpu_we & ~w_io_sel;

  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  assign w_empty   = (r_level == '0);
  // Fullness is judged on the registered level, so a same-cycle pop never rescues a push.
  assign w_push    = w_wr_tx & ~w_full;

  // A divider of 0 runs like 1: each bit lasts one cycle.
  assign w_reload  = (r_baud == 16'd0) ? 16'd0 : (r_baud - 16'd1);

  assign w_status  = {23'd0, 5'(r_level), r_ovf, (r_state != S_IDLE), w_empty, w_full};

  // IO register read mux, indexed by the low address nibble.
  always_comb begin
    w_io_val = 32'd0;
    case (w_idx)
      4'd0:    w_io_val = {24'd0, r_led};
      4'd1:    w_io_val = r_cycle;
      4'd2:    w_io_val = w_status;
      4'd4:    w_io_val = {16'd0, r_baud};
      default: w_io_val = 32'd0;
    endcase
  end

  // Control/status registers, read pipeline, FIFO pointers and level.
  always_ff @(posedge clk) begin
    if (nRst) begin
      r_led        <= 8'd0;
      r_cycle      <= 32'd0;
      r_baud       <= BAUD_RESET;
      r_ovf        <= 1'b0;
      r_sel_q      <= 1'b0;
      r_io_rdata_q <= 32'd0;
      r_irq        <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
    end else begin
      r_sel_q      <= w_io_sel;
      r_io_rdata_q <= w_io_val;
      r_irq        <= w_empty & (r_state == S_IDLE);
      if (w_wr_led)  r_led  <= cpu_wdata[7:0];
      if (w_wr_baud) r_baud <= cpu_wdata[15:0];
      if (w_wr_cyc)  r_cycle <= cpu_wdata;
      else           r_cycle <= r_cycle + 32'd1;
      if (w_wr_tx & w_full)                r_ovf <= 1'b1;
      else if (w_wr_stat & cpu_wdata[3])   r_ovf <= 1'b0;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FIFO storage; contents need no reset since the level gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= cpu_wdata[7:0];
  end

  // UART state, shifter and bit timer registers.
  always_ff @(posedge clk) begin
    if (nRst) begin
      r_state <= S_IDLE;
      r_shift <= 8'd0;
      r_bcnt  <= 16'd0;
      r_bidx  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_bidx  <= w_bidx_nxt;
    end
  end

  // UART 8N1 next state; the bit timer reloads from the live divider at each bit boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bcnt_nxt  = r_bcnt;
    w_bidx_nxt  = r_bidx;
    w_pop       = 1'b0;
    w_tx        = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_fifo[r_rptr];
          w_bcnt_nxt  = w_reload;
          w_bidx_nxt  = 3'd0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (r_bcnt == 16'd0) begin
          w_bcnt_nxt  = w_reload;
          w_state_nxt = S_DATA;
        end else begin
          w_bcnt_nxt = r_bcnt - 16'd1;
        end
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (r_bcnt == 16'd0) begin
          w_bcnt_nxt = w_reload;
          if (r_bidx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_bidx_nxt  = r_bidx + 3'd1;
          end
        end else begin
          w_bcnt_nxt = r_bcnt - 16'd1;
        end
      end
      S_STOP: begin
        if (r_bcnt == 16'd0) w_state_nxt = S_IDLE;
        else                 w_bcnt_nxt  = r_bcnt - 16'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign uart_tx      = w_tx;
  assign irq_tx_empty = r_irq;
  assign led          = r_led;
  assign cpu_rdata    = r_sel_q ? r_io_rdata_q : ram_rdata;

endmodule

// File: tb/tb_data_io_bridge.sv
// Scoreboard bench for data_io_bridge: reads queue expectations, a monitor checks them.
// Read results are compared one cycle after the address cycle.
// A bench UART receiver collects transmitted bytes for frame/overflow checks.
module tb_data_io_bridge;

  logic        clk = 1'b0;
  logic        nRst = 1'b1;
  logic [13:0] cpu_addr = 14'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_rdata;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic [7:0]  led;
  logic        uart_tx;
  logic        irq_tx_empty;

  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];
  logic [7:0]  rx_q [$];
  logic        rd_issue = 1'b0;
  logic        rd_pipe = 1'b0;
  int          baud_cur = 434;
  logic [31:0] mem [256];
  logic [9:0]  seq55 = 10'b1010101010;

  data_io_bridge dut (
    .clk(clk), .nRst(nRst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .led(led), .uart_tx(uart_tx), .irq_tx_empty(irq_tx_empty)
  );

  always #5 clk = ~clk;

  // Block RAM model with synchronous 1-cycle read, cleared during reset.
  always @(posedge clk) begin
    if (nRst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else if (ram_we) begin
      mem[cpu_addr[7:0]] <= cpu_wdata;
    end
    ram_rdata <= mem[cpu_addr[7:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Monitor: a read issued in cycle k presents its data in cycle k+1.
  always @(posedge clk) rd_pipe <= rd_issue;

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    string       nm;
    if (rd_pipe) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, cpu_rdata, e);
      end
    end
  end

  // Bench UART receiver: mid-bit sampling at the current divider.
  initial begin : rx
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        repeat (baud_cur / 2) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (baud_cur) @(negedge clk);
          b[j] = uart_tx;
        end
        repeat (baud_cur) @(negedge clk);
        rx_q.push_back(b);
      end
    end
  end

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1; rd_issue = 1'b0;
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic wr_we(input logic [13:0] a, input logic [31:0] d, input logic exp_we, input string nm);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1; rd_issue = 1'b0;
    #1;
    chk(nm, {31'd0, ram_we}, {31'd0, exp_we});
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a, input logic [31:0] exp, input string nm);
    cpu_addr = a; cpu_we = 1'b0; rd_issue = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic wait_low(input string nm);
    int k = 0;
    while (uart_tx !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(nm, {31'd0, uart_tx}, 32'd0);
  endtask

  initial begin : main
    int k;
    int lows;
    // Reset held for 3 cycles
    nRst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_led", {24'd0, led}, 32'd0);
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_irq", {31'd0, irq_tx_empty}, 32'd0);
    chk("rst_rdata_ram", cpu_rdata, 32'd0);
    nRst = 1'b0;
    rd(14'h3FF1, 32'd0, "cycle_0");
    rd(14'h3FF1, 32'd1, "cycle_1");
    rd(14'h3FF1, 32'd2, "cycle_2");
    rd(14'h3FF2, 32'h2, "rst_status");
    rd(14'h3FF4, 32'd434, "rst_baud");
    chk("irq_idle", {31'd0, irq_tx_empty}, 32'd1);

    // Read latency and decode
    wr_we(14'h0010, 32'hDEADBEEF, 1'b1, "ram_we_ram");
    rd(14'h0010, 32'hDEADBEEF, "ram_rd");
    rd(14'h3FF0, 32'd0, "led_rd0");
    wr_we(14'h3FF0, 32'h000000A5, 1'b0, "ram_we_io");
    chk("led_a5", {24'd0, led}, 32'hA5);
    rd(14'h3FF0, 32'hA5, "led_rd");
    rd(14'h00F0, 32'd0, "ram_not_written");
    rd(14'h3FF7, 32'd0, "unmapped_rd");
    rd(14'h3FF3, 32'd0, "tx_reads0");

    // UART frame 0x55 at BAUD_DIV=4
    baud_cur = 4;
    wr(14'h3FF4, 32'd4);
    rd(14'h3FF4, 32'd4, "baud_rd");
    wr(14'h3FF3, 32'h55);
    wait_low("start55");
    for (int i = 0; i < 40; i++) begin
      chk("tx55_bit", {31'd0, uart_tx}, {31'd0, seq55[i/4]});
      if (i == 10) begin
        cpu_addr = 14'h3FF2; cpu_we = 1'b0; rd_issue = 1'b1;
        exp_q.push_back(32'h6);
        name_q.push_back("busy_status");
      end else begin
        rd_issue = 1'b0;
      end
      @(negedge clk);
    end
    rd_issue = 1'b0;
    chk("tx55_idle", {31'd0, uart_tx}, 32'd1);
    chk("irq_stop_edge", {31'd0, irq_tx_empty}, 32'd0);
    @(negedge clk);
    chk("irq_after_stop", {31'd0, irq_tx_empty}, 32'd1);
    chk("rx55_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() != 0) chk("rx55_byte", {24'd0, rx_q.pop_front()}, 32'h55);

    // FIFO full / overflow at BAUD_DIV=100
    baud_cur = 100;
    wr(14'h3FF4, 32'd100);
    for (int b = 1; b <= 6; b++) wr(14'h3FF3, 32'(b));
    rd(14'h3FF2, 32'h4D, "ovf_status");
    wr(14'h3FF2, 32'h8);
    rd(14'h3FF2, 32'h45, "ovf_cleared");
    k = 0;
    while (rx_q.size() < 5 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    chk("ovf_rx_count", 32'(rx_q.size()), 32'd5);
    for (int b = 1; b <= 5; b++) begin
      if (rx_q.size() != 0) chk("ovf_rx_byte", {24'd0, rx_q.pop_front()}, 32'(b));
    end
    repeat (1100) @(negedge clk);
    chk("byte6_dropped", 32'(rx_q.size()), 32'd0);
    rd(14'h3FF2, 32'h2, "drained_status");

    // Counter load and wrap
    wr(14'h3FF1, 32'hFFFFFFFE);
    rd(14'h3FF1, 32'hFFFFFFFE, "cyc_load");
    rd(14'h3FF1, 32'hFFFFFFFF, "cyc_max");
    rd(14'h3FF1, 32'h00000000, "cyc_wrap");

    // Reset during DATA bit 3 of 0xF7 (bit3 = 0)
    baud_cur = 4;
    wr(14'h3FF4, 32'd4);
    wr(14'h3FF3, 32'hF7);
    wait_low("start_mid");
    wr(14'h3FF3, 32'h81);
    wr(14'h3FF3, 32'h7E);
    repeat (15) @(negedge clk);
    chk("mid_bit3_low", {31'd0, uart_tx}, 32'd0);
    nRst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
    nRst = 1'b0;
    rd(14'h3FF2, 32'h2, "mid_rst_status");
    rd(14'h3FF4, 32'd434, "mid_rst_baud");
    rd(14'h3FF0, 32'd0, "mid_rst_led");
    repeat (40) @(negedge clk);
    rx_q.delete();
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      if (uart_tx !== 1'b1) lows++;
      @(negedge clk);
    end
    chk("queued_discarded", 32'(lows), 32'd0);
    chk("no_rx_after_rst", 32'(rx_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
